// File: rtl/nco_sweep_controller.sv
// -----------------------------------------------------------------------------
// nco_sweep_controller
//
// Frequency-sweep scheduler for the phase accumulator write port. It steps a
// tuning word from start_ftw toward stop_ftw by a signed step and holds each
// value for max(dwell_len,1) cycles. The last value is stop_ftw only when it is
// reached exactly. Sweeps run once (single-shot) or repeat back-to-back
// (continuous).
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       sweep start request, honoured only in IDLE
//   abort       terminate the sweep from any state (wins over start)
//   continuous  1 = restart at start_ftw after each sweep (latched on start)
//   start_ftw   first tuning word, unsigned (latched on start)
//   stop_ftw    end bound, unsigned (latched on start)
//   step_ftw    signed two's-complement increment (latched on start)
//   dwell_len   cycles each tuning word is held, 0 acts as 1 (latched on start)
//   ftw_out     tuning word to the phase accumulator
//   ftw_we      one-cycle write strobe on the first cycle of each dwell
//   busy        high while a sweep is running
//   done        one-cycle pulse when a single-shot sweep completes
//   sweep_cnt   completed sweeps since the last start, saturating
// -----------------------------------------------------------------------------
module nco_sweep_controller #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [FTW_W-1:0]   start_ftw,
  input  logic [FTW_W-1:0]   stop_ftw,
  input  logic [FTW_W-1:0]   step_ftw,
  input  logic [DWELL_W-1:0] dwell_len,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               ftw_we,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [FTW_W-1:0]   ftw_q;
  logic               ftw_we_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   sweep_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;

  // Configuration captured at start acceptance
  logic [FTW_W-1:0]   start_cfg_q;
  logic [FTW_W-1:0]   stop_cfg_q;
  logic [FTW_W-1:0]   step_cfg_q;
  logic [DWELL_W-1:0] dwell_cfg_q;
  logic               cont_cfg_q;

  // Two extra bits so that the sum can neither wrap past 2^FTW_W nor below 0
  logic signed [FTW_W+1:0] next_ftw_s;
  logic signed [FTW_W+1:0] stop_ext_s;
  logic                    sweep_end_s;

  // Remaining-cycle count loaded at the start of a dwell: D-1, with D = max(len,1)
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] len);
    if (len == {DWELL_W{1'b0}}) begin
      return {DWELL_W{1'b0}};
    end else begin
      return len - {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Saturating increment of the completed-sweep counter
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) begin
      return cnt;
    end else begin
      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Candidate next tuning word and end-of-sweep decision
  always_comb begin
    next_ftw_s  = {2'b00, ftw_q} + {{2{step_cfg_q[FTW_W-1]}}, step_cfg_q};
    stop_ext_s  = {2'b00, stop_cfg_q};
    sweep_end_s = 1'b0;
    if (step_cfg_q == {FTW_W{1'b0}}) begin
      sweep_end_s = 1'b1;
    end else if (step_cfg_q[FTW_W-1] == 1'b0) begin
      sweep_end_s = (next_ftw_s > stop_ext_s);
    end else begin
      sweep_end_s = (next_ftw_s < stop_ext_s);
    end
  end

  // Sweep FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ftw_q       <= {FTW_W{1'b0}};
      ftw_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_cnt_q <= {CNT_W{1'b0}};
      dwell_cnt_q <= {DWELL_W{1'b0}};
      start_cfg_q <= {FTW_W{1'b0}};
      stop_cfg_q  <= {FTW_W{1'b0}};
      step_cfg_q  <= {FTW_W{1'b0}};
      dwell_cfg_q <= {DWELL_W{1'b0}};
      cont_cfg_q  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      ftw_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort) begin
        // ftw_out and sweep_cnt deliberately hold their values
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              start_cfg_q <= start_ftw;
              stop_cfg_q  <= stop_ftw;
              step_cfg_q  <= step_ftw;
              dwell_cfg_q <= dwell_len;
              cont_cfg_q  <= continuous;
              sweep_cnt_q <= {CNT_W{1'b0}};
              ftw_q       <= start_ftw;
              ftw_we_q    <= 1'b1;
              busy_q      <= 1'b1;
              dwell_cnt_q <= dwell_reload(dwell_len);
              state_q     <= ST_DWELL;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_DWELL: begin
            if (dwell_cnt_q != {DWELL_W{1'b0}}) begin
              dwell_cnt_q <= dwell_cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
            end else if (!sweep_end_s) begin
              ftw_q       <= next_ftw_s[FTW_W-1:0];
              ftw_we_q    <= 1'b1;
              dwell_cnt_q <= dwell_reload(dwell_cfg_q);
            end else begin
              sweep_cnt_q <= cnt_sat_inc(sweep_cnt_q);
              if (cont_cfg_q) begin
                // Restart with no gap: the write spacing stays D
                ftw_q       <= start_cfg_q;
                ftw_we_q    <= 1'b1;
                dwell_cnt_q <= dwell_reload(dwell_cfg_q);
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ftw_out   = ftw_q;
  assign ftw_we    = ftw_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for nco_sweep_controller. Each sweep start pushes the
// expected writes (cycle, value) and the expected done cycle into queues. A
// negedge monitor pops and compares them as the DUT produces strobes.
// -----------------------------------------------------------------------------
module tb_nco_sweep_controller;

  localparam int FTW_W   = 32;
  localparam int DWELL_W = 16;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic               continuous;
  logic [FTW_W-1:0]   start_ftw;
  logic [FTW_W-1:0]   stop_ftw;
  logic [FTW_W-1:0]   step_ftw;
  logic [DWELL_W-1:0] dwell_len;
  logic [FTW_W-1:0]   ftw_out;
  logic               ftw_we;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sweep_cnt;

  nco_sweep_controller #(.FTW_W(FTW_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .start_ftw(start_ftw), .stop_ftw(stop_ftw), .step_ftw(step_ftw),
    .dwell_len(dwell_len), .ftw_out(ftw_out), .ftw_we(ftw_we), .busy(busy),
    .done(done), .sweep_cnt(sweep_cnt)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } wr_ev_t;

  wr_ev_t wr_q[$];
  int     done_q[$];
  int     cyc;
  int     n_checks;
  int     n_pass;
  int     exp_cnt;
  bit     mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: constant between rising edges, read at falling edges
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference sweep: expected writes up to last_cyc, and the done cycle if single-shot
  task automatic plan(input int c0, input longint s, input longint e, input longint stp,
                      input int dl, input bit cont, input int last_cyc);
    int     k;
    int     d;
    int     sweeps;
    longint v;
    longint nxt;
    bit     fin;
    wr_ev_t ev;
    d      = (dl == 0) ? 1 : dl;
    k      = 1;
    sweeps = 0;
    v      = s;
    while (c0 + k <= last_cyc) begin
      ev.cyc = c0 + k;
      ev.val = v[31:0];
      wr_q.push_back(ev);
      nxt = v + stp;
      fin = (stp == 0) || (stp > 0 && nxt > e) || (stp < 0 && nxt < e);
      k   = k + d;
      if (fin) begin
        sweeps++;
        if (cont) begin
          v = s;
        end else begin
          done_q.push_back(c0 + k);
          exp_cnt = sweeps;
          break;
        end
      end else begin
        v = nxt;
      end
    end
  endtask

  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] stp,
                             input int dl, input bit cont, input int last_rel, output int c0);
    @(negedge clk);
    c0         = cyc;
    start_ftw  = s;
    stop_ftw   = e;
    step_ftw   = stp;
    dwell_len  = dl[DWELL_W-1:0];
    continuous = cont;
    start      = 1'b1;
    plan(c0, longint'(s), longint'(e), longint'($signed(stp)), dl, cont, c0 + last_rel);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Bounded wait for the scoreboard to drain; leftovers count as failures
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (wr_q.size() == 0 && done_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check_eq({tag, "_wr_left"}, wr_q.size(), 0);
    check_eq({tag, "_done_left"}, done_q.size(), 0);
    wr_q.delete();
    done_q.delete();
  endtask

  // Monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    wr_ev_t ev;
    int     dc;
    if (mon_en) begin
      if (ftw_we) begin
        if (wr_q.size() == 0) begin
          check_eq("we_unexpected", ftw_we, 0);
        end else begin
          ev = wr_q.pop_front();
          check_eq("we_value", ftw_out, ev.val);
          check_eq("we_cycle", cyc, ev.cyc);
          check_eq("we_busy", busy, 1);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", done, 0);
        end else begin
          dc = done_q.pop_front();
          check_eq("done_cycle", cyc, dc);
          check_eq("done_busy", busy, 0);
        end
      end
    end
  end

  initial begin
    int c0;
    cyc = 0; n_checks = 0; n_pass = 0; exp_cnt = 0; mon_en = 1'b0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    start_ftw = 32'd0; stop_ftw = 32'd0; step_ftw = 32'd0; dwell_len = 16'd0;

    // Reset state
    #22 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ftw", ftw_out, 0);
    check_eq("rst_we", ftw_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cnt", sweep_cnt, 0);
    mon_en = 1'b1;

    // Basic up sweep: writes at +1,+4,+7,+10, done at +13
    start_sweep(32'd100, 32'd130, 32'd10, 3, 1'b0, 1000, c0);
    wait_cyc(c0 + 12);
    check_eq("up_busy_before_done", busy, 1);
    wait_idle("up");
    check_eq("up_cnt", sweep_cnt, exp_cnt);
    check_eq("up_busy_after", busy, 0);

    // Exact down sweep with D=1: 50,35,20
    start_sweep(32'd50, 32'd20, 32'hFFFF_FFF1, 0, 1'b0, 1000, c0);
    wait_idle("down_exact");
    // Non-exact: 50,35 then done, 20 never emitted
    start_sweep(32'd50, 32'd25, 32'hFFFF_FFF1, 0, 1'b0, 1000, c0);
    wait_idle("down_inexact");
    check_eq("down_last_ftw", ftw_out, 35);

    // Wrap guard: only 0xFFFFFFF0
    start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 2, 1'b0, 1000, c0);
    wait_idle("wrap");
    check_eq("wrap_ftw_hold", ftw_out, 32'hFFFF_FFF0);

    // Zero step and start already past stop: one dwell each
    start_sweep(32'd5, 32'd0, 32'd0, 1, 1'b0, 1000, c0);
    wait_idle("step0");
    start_sweep(32'd200, 32'd100, 32'd10, 2, 1'b0, 1000, c0);
    wait_idle("beyond");

    // Continuous 0,1,2,0,1 then abort during cycle +9
    start_sweep(32'd0, 32'd2, 32'd1, 2, 1'b1, 9, c0);
    wait_cyc(c0 + 6);
    check_eq("cont_cnt0", sweep_cnt, 0);
    wait_cyc(c0 + 8);
    check_eq("cont_cnt1", sweep_cnt, 1);
    wait_cyc(c0 + 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ftw_hold", ftw_out, 1);
    check_eq("abort_cnt_hold", sweep_cnt, 1);
    check_eq("abort_no_done", done, 0);
    repeat (6) @(negedge clk);
    check_eq("abort_wr_left", wr_q.size(), 0);
    wr_q.delete();

    // Start and abort together in IDLE: nothing starts
    @(negedge clk);
    start_ftw = 32'd77; stop_ftw = 32'd99; step_ftw = 32'd1; dwell_len = 16'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("coll_busy1", busy, 0);
    @(negedge clk);
    check_eq("coll_busy2", busy, 0);
    check_eq("coll_ftw_hold", ftw_out, 1);

    // Start while busy with different config is ignored
    start_sweep(32'd100, 32'd130, 32'd10, 3, 1'b0, 1000, c0);
    wait_cyc(c0 + 5);
    start_ftw = 32'd7; stop_ftw = 32'd9999; step_ftw = 32'd1; dwell_len = 16'd1;
    continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    check_eq("busy_start_cnt", sweep_cnt, exp_cnt);

    // Reset mid-sweep: immediate reset values, no writes afterwards
    start_sweep(32'd0, 32'd2, 32'd1, 2, 1'b1, 3, c0);
    wait_cyc(c0 + 4);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ftw", ftw_out, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cnt", sweep_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("post_rst_wr_left", wr_q.size(), 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_ftw", ftw_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
